// File: rtl/writeback_stage_pkg.sv
// ============================================================================
// writeback_stage_pkg : shared types and opcode constants for the writeback stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package writeback_stage_pkg;

  localparam int OPCODE_NAME_WIDTH = 96;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ECALL_REQ = 2'd1,
    ST_ECALL_RET = 2'd2
  } wb_state_t;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_t;

  typedef struct packed {
    logic     is_load_op;
    ld_size_t size;
    logic     is_signed;
  } ld_decode_t;

  // Opcode names are ASCII, right-justified and zero-padded to 12 characters.
  localparam logic [OPCODE_NAME_WIDTH-1:0] OP_LB    = {80'd0, "lb"};
  localparam logic [OPCODE_NAME_WIDTH-1:0] OP_LBU   = {72'd0, "lbu"};
  localparam logic [OPCODE_NAME_WIDTH-1:0] OP_LH    = {80'd0, "lh"};
  localparam logic [OPCODE_NAME_WIDTH-1:0] OP_LHU   = {72'd0, "lhu"};
  localparam logic [OPCODE_NAME_WIDTH-1:0] OP_LW    = {80'd0, "lw"};
  localparam logic [OPCODE_NAME_WIDTH-1:0] OP_LWU   = {72'd0, "lwu"};
  localparam logic [OPCODE_NAME_WIDTH-1:0] OP_LD    = {80'd0, "ld"};
  localparam logic [OPCODE_NAME_WIDTH-1:0] OP_ECALL = {56'd0, "ecall"};

  function automatic ld_decode_t decode_load(input logic [OPCODE_NAME_WIDTH-1:0] name);
    ld_decode_t d;
    d.is_load_op = 1'b1;
    d.size       = LD_D;
    d.is_signed  = 1'b0;
    case (name)
      OP_LB:   begin d.size = LD_B; d.is_signed = 1'b1; end
      OP_LBU:  begin d.size = LD_B; d.is_signed = 1'b0; end
      OP_LH:   begin d.size = LD_H; d.is_signed = 1'b1; end
      OP_LHU:  begin d.size = LD_H; d.is_signed = 1'b0; end
      OP_LW:   begin d.size = LD_W; d.is_signed = 1'b1; end
      OP_LWU:  begin d.size = LD_W; d.is_signed = 1'b0; end
      OP_LD:   begin d.size = LD_D; d.is_signed = 1'b0; end
      default: d.is_load_op = 1'b0;
    endcase
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_load_extract.sv
// ============================================================================
// wb_load_extract : combinational byte/half/word/double extraction from a load doubleword
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_load_extract
  import writeback_stage_pkg::*;
(
  input  logic [63:0] mdata,
  input  logic [2:0]  offset,
  input  ld_size_t    size,
  input  logic        is_signed,
  output logic [63:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] word_sel;

  // Sub-doubleword lanes use the offset masked down to natural alignment.
  assign byte_sel = mdata[{offset, 3'b000} +: 8];
  assign half_sel = mdata[{offset[2:1], 4'b0000} +: 16];
  assign word_sel = mdata[{offset[2], 5'b00000} +: 32];

  always_comb begin
    data       = mdata;
    misaligned = 1'b0;
    case (size)
      LD_B: begin
        data       = is_signed ? {{56{byte_sel[7]}}, byte_sel} : {56'd0, byte_sel};
        misaligned = 1'b0;
      end
      LD_H: begin
        data       = is_signed ? {{48{half_sel[15]}}, half_sel} : {48'd0, half_sel};
        misaligned = offset[0];
      end
      LD_W: begin
        data       = is_signed ? {{32{word_sel[31]}}, word_sel} : {32'd0, word_sel};
        misaligned = |offset[1:0];
      end
      default: begin
        data       = mdata;
        misaligned = |offset;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/writeback_stage.sv
// ============================================================================
// writeback_stage : register-file write port, load extension and ecall hand-off
// Optional: WB_RETIRE_CNT_EN adds out_instret / out_loadret retire counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int REGISTER_WIDTH         = 64,
  parameter int REGISTERNO_WIDTH       = 5,
  parameter int INSTRUCTION_NAME_WIDTH = 96,
  parameter int SYSCALL_RET_REGNO      = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  input  logic [REGISTER_WIDTH-1:0]         in_alu_result,
  input  logic [REGISTER_WIDTH-1:0]         in_mdata,
  input  logic [REGISTERNO_WIDTH-1:0]       in_rd_regno,
  input  logic                              in_update_rd_bool,
  input  logic                              in_mm_load_bool,
  input  logic [INSTRUCTION_NAME_WIDTH-1:0] in_opcode_name,
  input  logic                              in_syscall_done,
  input  logic [REGISTER_WIDTH-1:0]         in_syscall_ret,
  output logic                              out_stall,
  output logic                              out_rf_wr_en,
  output logic [REGISTERNO_WIDTH-1:0]       out_rf_wr_regno,
  output logic [REGISTER_WIDTH-1:0]         out_rf_wr_data,
  output logic                              out_syscall_req,
  output logic                              out_syscall_flush,
  output logic                              out_misaligned
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]                       out_instret,
  output logic [63:0]                       out_loadret
`endif
);

  wb_state_t   state;
  ld_decode_t  dec;
  logic [63:0] ext_data;
  logic        ext_misaligned;
  logic        is_ecall;
  logic        use_load_path;

  assign dec           = decode_load(in_opcode_name);
  assign is_ecall      = (in_opcode_name == OP_ECALL);
  // An unrecognised opcode falls back to the ALU result even if flagged as a load.
  assign use_load_path = in_mm_load_bool && dec.is_load_op;

  wb_load_extract u_load_extract (
    .mdata      (in_mdata),
    .offset     (in_alu_result[2:0]),
    .size       (dec.size),
    .is_signed  (dec.is_signed),
    .data       (ext_data),
    .misaligned (ext_misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      out_stall         <= 1'b0;
      out_rf_wr_en      <= 1'b0;
      out_rf_wr_regno   <= '0;
      out_rf_wr_data    <= '0;
      out_syscall_req   <= 1'b0;
      out_syscall_flush <= 1'b0;
      out_misaligned    <= 1'b0;
`ifdef WB_RETIRE_CNT_EN
      out_instret       <= '0;
      out_loadret       <= '0;
`endif
    end else begin
      out_rf_wr_en      <= 1'b0;
      out_syscall_flush <= 1'b0;
      out_misaligned    <= 1'b0;
      case (state)
        ST_IDLE: begin
          out_stall <= 1'b0;
          if (in_valid) begin
            if (is_ecall) begin
              state           <= ST_ECALL_REQ;
              out_syscall_req <= 1'b1;
              out_stall       <= 1'b1;
            end else begin
              out_rf_wr_en    <= in_update_rd_bool && (in_rd_regno != '0);
              out_rf_wr_regno <= in_rd_regno;
              out_rf_wr_data  <= use_load_path ? ext_data : in_alu_result;
              out_misaligned  <= use_load_path && ext_misaligned;
`ifdef WB_RETIRE_CNT_EN
              out_instret     <= out_instret + 64'd1;
              if (in_mm_load_bool)
                out_loadret   <= out_loadret + 64'd1;
`endif
            end
          end
        end
        ST_ECALL_REQ: begin
          if (in_syscall_done) begin
            state             <= ST_ECALL_RET;
            out_rf_wr_en      <= 1'b1;
            out_rf_wr_regno   <= REGISTERNO_WIDTH'(SYSCALL_RET_REGNO);
            out_rf_wr_data    <= in_syscall_ret;
            out_syscall_flush <= 1'b1;
            out_syscall_req   <= 1'b0;
`ifdef WB_RETIRE_CNT_EN
            out_instret       <= out_instret + 64'd1;
`endif
          end
        end
        ST_ECALL_RET: begin
          state     <= ST_IDLE;
          out_stall <= 1'b0;
        end
        default: begin
          state           <= ST_IDLE;
          out_stall       <= 1'b0;
          out_syscall_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
